// File: rtl/rns_err_pkg.sv
// Shared types and default widths for the residue error event monitor.
// Imported by the monitor top and its counter sub-module.
package rns_err_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } err_state_e;

  localparam int ERR_CNT_W    = 16;
  localparam int ERR_IDX_W    = 16;
  localparam int ERR_BURST_TH = 4;

endpackage

// File: rtl/sat_counter.sv
// Parameterised up-counter with synchronous clear and optional saturation.
// clr together with inc loads 1, so a same-cycle event is never dropped.
module sat_counter #(
  parameter int W   = 8,
  parameter bit SAT = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = inc ? W'(1) : '0;
    end else if (inc && !(SAT && (&q_q))) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/rns_err_event_monitor.sv
// Qualifies merged residue error flags, counts events and bursts, raises irq.
// Define ERR_MON_FIRST_IDX_EN to keep the first-error word index capture.
module rns_err_event_monitor
  import rns_err_pkg::*;
#(
  parameter int CNT_W    = ERR_CNT_W,
  parameter int IDX_W    = ERR_IDX_W,
  parameter int BURST_TH = ERR_BURST_TH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             err_in,
  input  logic             valid_in,
  input  logic             ack,
  input  logic             clr_cnt,
  output logic             err_irq,
  output logic             err_sticky,
  output logic             err_burst,
  output logic [CNT_W-1:0] err_count,
  output logic [IDX_W-1:0] first_err_idx
);

  localparam logic [CNT_W-1:0] TH   = CNT_W'(BURST_TH);
  localparam logic [CNT_W-1:0] THM1 = CNT_W'(BURST_TH - 1);

  err_state_e       state_q, state_d;
  logic             irq_q, irq_d;
  logic             sticky_q, sticky_d;
  logic             burst_q, burst_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] run_cnt;
  logic             ev;
  logic             eff_ack;
  logic             run_inc;
  logic             run_clr;

  assign ev      = valid_in & err_in;
  // an event in the ack cycle wins, so the ack is dropped entirely
  assign eff_ack = ack & (state_q == PEND) & ~ev;
  assign run_inc = ev & (run_cnt != TH);
  assign run_clr = (valid_in & ~err_in) | eff_ack;

  sat_counter #(
    .W   (CNT_W),
    .SAT (1'b1)
  ) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ev),
    .clr   (clr_cnt),
    .q     (err_count)
  );

  sat_counter #(
    .W   (CNT_W),
    .SAT (1'b0)
  ) u_run_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (run_inc),
    .clr   (run_clr),
    .q     (run_cnt)
  );

  always_comb begin
    idx_d = idx_q;
    if (clr_cnt) begin
      idx_d = valid_in ? IDX_W'(1) : '0;
    end else if (valid_in) begin
      idx_d = idx_q + IDX_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    irq_d    = irq_q;
    sticky_d = sticky_q;
    burst_d  = burst_q;
    unique case (state_q)
      IDLE: if (ev) state_d = PEND;
      PEND: if (eff_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    irq_d    = (state_d == PEND);
    sticky_d = (state_d == PEND);
    if (eff_ack) begin
      burst_d = 1'b0;
    end else if (ev && (run_cnt >= THM1)) begin
      burst_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      irq_q    <= 1'b0;
      sticky_q <= 1'b0;
      burst_q  <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      irq_q    <= irq_d;
      sticky_q <= sticky_d;
      burst_q  <= burst_d;
      idx_q    <= idx_d;
    end
  end

`ifdef ERR_MON_FIRST_IDX_EN
  logic [IDX_W-1:0] first_q, first_d;

  always_comb begin
    first_d = first_q;
    if (ev && ((state_q == IDLE) || ack)) begin
      first_d = idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      first_q <= '0;
    end else begin
      first_q <= first_d;
    end
  end

  assign first_err_idx = first_q;
`else
  assign first_err_idx = '0;
`endif

  assign err_irq    = irq_q;
  assign err_sticky = sticky_q;
  assign err_burst  = burst_q;

endmodule

// File: tb/tb_rns_err_event_monitor.sv
// Bench for rns_err_event_monitor: default-width and 3-bit instances share
// one stimulus stream and are checked every cycle against a behavioural model.
module tb_rns_err_event_monitor;

  logic clk;
  logic reset;
  logic err_in;
  logic valid_in;
  logic ack;
  logic clr_cnt;

  logic        irq0, sticky0, burst0;
  logic [15:0] cnt0, first0;
  logic        irq1, sticky1, burst1;
  logic [2:0]  cnt1, first1;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  rns_err_event_monitor u_dut (
    .clk           (clk),
    .reset         (reset),
    .err_in        (err_in),
    .valid_in      (valid_in),
    .ack           (ack),
    .clr_cnt       (clr_cnt),
    .err_irq       (irq0),
    .err_sticky    (sticky0),
    .err_burst     (burst0),
    .err_count     (cnt0),
    .first_err_idx (first0)
  );

  rns_err_event_monitor #(
    .CNT_W    (3),
    .IDX_W    (3),
    .BURST_TH (4)
  ) u_small (
    .clk           (clk),
    .reset         (reset),
    .err_in        (err_in),
    .valid_in      (valid_in),
    .ack           (ack),
    .clr_cnt       (clr_cnt),
    .err_irq       (irq1),
    .err_sticky    (sticky1),
    .err_burst     (burst1),
    .err_count     (cnt1),
    .first_err_idx (first1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: index 0 = default widths, index 1 = 3-bit widths
  localparam int TH = 4;
  int cmax[2] = '{65535, 7};
  int imod[2] = '{65536, 8};
  int m_cnt[2]   = '{0, 0};
  int m_idx[2]   = '{0, 0};
  int m_run[2]   = '{0, 0};
  int m_first[2] = '{0, 0};
  bit m_pend[2]  = '{0, 0};
  bit m_burst[2] = '{0, 0};

  function automatic int exp_first(input int v);
`ifdef ERR_MON_FIRST_IDX_EN
    return v;
`else
    return 0;
`endif
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit ev, eack;
      ev   = valid_in && err_in;
      eack = ack && m_pend[k] && !ev;
      if (reset) begin
        m_cnt[k] = 0; m_idx[k] = 0; m_run[k] = 0;
        m_first[k] = 0; m_pend[k] = 0; m_burst[k] = 0;
      end else begin
        if (ev && (!m_pend[k] || ack)) m_first[k] = m_idx[k];
        if (clr_cnt) m_cnt[k] = ev ? 1 : 0;
        else if (ev && m_cnt[k] < cmax[k]) m_cnt[k]++;
        if (clr_cnt) m_idx[k] = valid_in ? 1 : 0;
        else if (valid_in) m_idx[k] = (m_idx[k] + 1) % imod[k];
        if (eack) begin
          m_run[k] = 0;
          m_burst[k] = 0;
        end else begin
          if (valid_in) m_run[k] = ev ? ((m_run[k] < TH) ? m_run[k] + 1 : TH) : 0;
          if (m_run[k] == TH) m_burst[k] = 1;
        end
        if (ev) m_pend[k] = 1;
        else if (eack) m_pend[k] = 0;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("irq0",    32'(irq0),    32'(m_pend[0]));
      check("sticky0", 32'(sticky0), 32'(m_pend[0]));
      check("burst0",  32'(burst0),  32'(m_burst[0]));
      check("cnt0",    32'(cnt0),    32'(m_cnt[0]));
      check("first0",  32'(first0),  32'(exp_first(m_first[0])));
      check("irq1",    32'(irq1),    32'(m_pend[1]));
      check("sticky1", 32'(sticky1), 32'(m_pend[1]));
      check("burst1",  32'(burst1),  32'(m_burst[1]));
      check("cnt1",    32'(cnt1),    32'(m_cnt[1]));
      check("first1",  32'(first1),  32'(exp_first(m_first[1])));
    end
  end

  task automatic tick(input bit v, input bit e, input bit a, input bit c);
    valid_in = v;
    err_in   = e;
    ack      = a;
    clr_cnt  = c;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    reset = 1'b0;
    chk_en = 1'b1;
    tick(0, 0, 0, 0);
    check("rst_irq", 32'(irq0), 0);
    check("rst_cnt", 32'(cnt0), 0);

    // single error at index 3
    for (int i = 0; i < 10; i++) begin
      tick(1, i == 3, 0, 0);
      if (i == 3) begin
        check("single_irq",    32'(irq0),    1);
        check("single_sticky", 32'(sticky0), 1);
        check("single_cnt",    32'(cnt0),    1);
        check("single_first",  32'(first0),  32'(exp_first(3)));
        check("single_burst",  32'(burst0),  0);
      end
    end
    tick(0, 0, 1, 0);
    check("ack_irq",    32'(irq0),    0);
    check("ack_sticky", 32'(sticky0), 0);
    check("ack_cnt",    32'(cnt0),    1);

    // burst: 3 errors, clean, 4 errors
    tick(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) tick(1, 1, 0, 0);
    tick(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(1, 1, 0, 0);
    check("burst_before", 32'(burst0), 0);
    tick(1, 1, 0, 0);
    check("burst_after",  32'(burst0), 1);
    check("burst_small",  32'(burst1), 1);

    // ack together with an error in PEND
    tick(0, 0, 1, 1);
    for (int i = 0; i < 9; i++) begin
      tick(1, (i == 2) || (i == 8), i == 8, 0);
      if (i == 2) check("sim_first2", 32'(first0), 32'(exp_first(2)));
    end
    check("sim_irq",   32'(irq0),   1);
    check("sim_first", 32'(first0), 32'(exp_first(8)));
    check("sim_cnt",   32'(cnt0),   2);
    check("sim_burst", 32'(burst0), 0);

    // saturation on the 3-bit counter
    tick(0, 0, 1, 0);
    for (int i = 0; i < 10; i++) tick(1, 1, 0, 0);
    check("sat_small", 32'(cnt1), 7);
    check("sat_big",   32'(cnt0), 12);

    // index wrap: error on the 9th valid word
    tick(0, 0, 1, 1);
    for (int i = 0; i < 8; i++) tick(1, 0, 0, 0);
    tick(1, 1, 0, 0);
    check("wrap_small", 32'(first1), 32'(exp_first(0)));
    check("wrap_big",   32'(first0), 32'(exp_first(8)));

    // clr_cnt with an event in the same cycle
    tick(1, 1, 0, 0);
    tick(1, 1, 0, 0);
    check("pre_clr", 32'(cnt0), 3);
    tick(1, 1, 0, 1);
    check("clr_ev_big",   32'(cnt0), 1);
    check("clr_ev_small", 32'(cnt1), 1);

    // gating: err_in without valid_in
    tick(0, 0, 1, 1);
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) tick(0, 1, 0, 0);
    check("gate_cnt", 32'(cnt0), 0);
    check("gate_irq", 32'(irq0), 0);
    tick(1, 1, 0, 0);
    check("gate_idx", 32'(first0), 32'(exp_first(3)));

    // mixed traffic
    for (int i = 0; i < 400; i++) begin
      tick(($urandom % 4) != 0, $urandom % 2,
           ($urandom % 8) == 0, ($urandom % 16) == 0);
    end

    // reset during PEND with count 5
    tick(0, 0, 1, 1);
    for (int i = 0; i < 5; i++) tick(1, 1, 0, 0);
    check("pre_rst_cnt", 32'(cnt0), 5);
    reset = 1'b1;
    tick(1, 1, 0, 0);
    tick(1, 1, 0, 0);
    reset = 1'b0;
    check("midrst_irq",    32'(irq0),    0);
    check("midrst_sticky", 32'(sticky0), 0);
    check("midrst_burst",  32'(burst0),  0);
    check("midrst_cnt",    32'(cnt0),    0);
    check("midrst_first",  32'(first0),  0);
    tick(0, 0, 0, 0);
    tick(1, 1, 0, 0);
    check("post_rst_first", 32'(first0), 32'(exp_first(0)));
    check("post_rst_cnt",   32'(cnt0),   1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
